// File: rtl/ra_lcb_cal.sv
// Calibration sequencer for the LCB strobe delay: sweeps every tap, counts fb_ok passes
// per tap, and programs the midpoint of the first contiguous passing window.
`ifndef LCBSDR_CONFIGWIDTH
`define LCBSDR_CONFIGWIDTH 4
`endif

module ra_lcb_cal #(
    parameter int               CFG_W       = `LCBSDR_CONFIGWIDTH,
    parameter logic [CFG_W-1:0] CFG_DEFAULT = {CFG_W{1'b0}},
    parameter int               SETTLE_CYC  = 4,
    parameter int               SAMPLE_CYC  = 16,
    parameter int               THRESH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fb_ok,
    output logic [CFG_W-1:0] cfg,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CFG_W-1:0] win_lo,
    output logic [CFG_W-1:0] win_hi
);

    localparam int HIT_W   = $clog2(SAMPLE_CYC + 1);
    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [HIT_W-1:0] THRESH_V    = HIT_W'(THRESH);
    localparam logic [CFG_W-1:0] CFG_MAX     = {CFG_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [HIT_W-1:0] hits_r;
    logic             fb_meta_r;
    logic             fb_sync_r;
    logic             run_open_r;
    logic             run_closed_r;
    logic             found_r;
    logic [CFG_W-1:0] cfg_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [CFG_W-1:0] win_lo_r;
    logic [CFG_W-1:0] win_hi_r;
    logic             tap_pass_s;
    logic [CFG_W:0]   win_sum_s;

    assign tap_pass_s = (hits_r >= THRESH_V);
    // Sum is one bit wider so the midpoint never wraps.
    assign win_sum_s  = {1'b0, win_lo_r} + {1'b0, win_hi_r};

    assign cfg    = cfg_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign win_lo = win_lo_r;
    assign win_hi = win_hi_r;

    // Sweep FSM, fb_ok synchronizer and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            hits_r       <= {HIT_W{1'b0}};
            fb_meta_r    <= 1'b0;
            fb_sync_r    <= 1'b0;
            run_open_r   <= 1'b0;
            run_closed_r <= 1'b0;
            found_r      <= 1'b0;
            cfg_r        <= CFG_DEFAULT;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            win_lo_r     <= {CFG_W{1'b0}};
            win_hi_r     <= {CFG_W{1'b0}};
        end else begin
            fb_meta_r <= fb_ok;
            fb_sync_r <= fb_meta_r;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r      <= ST_SETTLE;
                        cnt_r        <= {CNT_W{1'b0}};
                        cfg_r        <= {CFG_W{1'b0}};
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        err_r        <= 1'b0;
                        win_lo_r     <= {CFG_W{1'b0}};
                        win_hi_r     <= {CFG_W{1'b0}};
                        run_open_r   <= 1'b0;
                        run_closed_r <= 1'b0;
                        found_r      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        hits_r  <= {HIT_W{1'b0}};
                        state_r <= ST_SAMPLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (fb_sync_r) begin
                        hits_r <= hits_r + HIT_W'(1);
                    end
                    if (cnt_r == SAMPLE_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_EVAL;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    // Only the first contiguous run is tracked; passes after it closes are dropped.
                    if (tap_pass_s) begin
                        if (!run_open_r && !run_closed_r) begin
                            win_lo_r   <= cfg_r;
                            win_hi_r   <= cfg_r;
                            run_open_r <= 1'b1;
                            found_r    <= 1'b1;
                        end else if (run_open_r) begin
                            win_hi_r <= cfg_r;
                        end
                    end else if (run_open_r) begin
                        run_open_r   <= 1'b0;
                        run_closed_r <= 1'b1;
                    end
                    if (cfg_r != CFG_MAX) begin
                        cfg_r   <= cfg_r + CFG_W'(1);
                        state_r <= ST_SETTLE;
                    end else begin
                        state_r <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (found_r) begin
                        cfg_r <= win_sum_s[CFG_W:1];
                    end else begin
                        cfg_r <= CFG_DEFAULT;
                        err_r <= 1'b1;
                    end
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ra_lcb_cal.sv
// Directed bench for ra_lcb_cal: a small array model drives fb_ok from cfg, and
// expected sweep results are queued at start and checked when done rises.
module tb_ra_lcb_cal;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       fb_ok;
    logic [3:0] cfg;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] win_lo;
    logic [3:0] win_hi;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] cfg;
        logic [3:0] lo;
        logic [3:0] hi;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    ra_lcb_cal #(
        .CFG_W       (4),
        .CFG_DEFAULT (4'd0),
        .SETTLE_CYC  (4),
        .SAMPLE_CYC  (16),
        .THRESH      (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .fb_ok  (fb_ok),
        .cfg    (cfg),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .win_lo (win_lo),
        .win_hi (win_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Array model: which taps read back clean for each scenario.
    function automatic logic pat(input int mode, input logic [3:0] c);
        logic r;
        r = 1'b0;
        case (mode)
            0: r = 1'b0;
            1: r = (c >= 4'd5 && c <= 4'd9);
            2: r = (c >= 4'd2 && c <= 4'd3) || (c >= 4'd5 && c <= 4'd14);
            3: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // hazard: 0 none, 1 stray start at T+50, 2 reset when tap 8 is reached
    task automatic run_sweep(input int mode, input int hazard, input exp_t e);
        int   k;
        int   g;
        bit   aborted;
        exp_t got;
        aborted = 1'b0;
        g       = 0;
        @(negedge clk);
        start = 1'b1;
        if (hazard != 2) sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done_clr", {30'd0, done, err}, 32'd0);
        chk("start_cfg0", {28'd0, cfg}, 32'd0);
        while (!done && k < 400) begin
            if (k % 21 == 1 && k <= 316) chk("tap_entry", {28'd0, cfg}, (k - 1) / 21);
            if (k % 21 == 0 && k <= 336) chk("tap_hold", {28'd0, cfg}, k / 21 - 1);
            fb_ok = pat(mode, cfg);
            if (mode == 2 && cfg == 4'd6) begin
                g++;
                if (g == 10) fb_ok = 1'b0;
            end
            if (hazard == 1) start = (k == 50);
            if (hazard == 2 && cfg == 4'd8) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("abort_state", {cfg, win_lo, win_hi, busy, done, err}, 32'd0);
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    chk("abort_idle", {28'd0, cfg, busy}, 32'd0);
                end
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!aborted) begin
            chk("done_latency", k, 32'd338);
            chk("done_busy", {31'd0, busy}, 32'd0);
            got = '{cfg: cfg, lo: win_lo, hi: win_hi, err: err};
            e   = sb_q.pop_front();
            chk("res_cfg", {28'd0, got.cfg}, {28'd0, e.cfg});
            chk("res_win_lo", {28'd0, got.lo}, {28'd0, e.lo});
            chk("res_win_hi", {28'd0, got.hi}, {28'd0, e.hi});
            chk("res_err", {31'd0, got.err}, {31'd0, e.err});
            repeat (3) @(negedge clk);
            chk("done_hold", {31'd0, done}, 32'd1);
            chk("cfg_hold", {28'd0, cfg}, {28'd0, e.cfg});
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fb_ok = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_cfg", {28'd0, cfg}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        chk("rst_win", {24'd0, win_lo, win_hi}, 32'd0);

        // Reset and start together: reset must win.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_vs_start", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst_vs_start_idle", {31'd0, busy}, 32'd0);

        run_sweep(0, 0, '{cfg: 4'd0, lo: 4'd0, hi: 4'd0, err: 1'b1});
        run_sweep(1, 0, '{cfg: 4'd7, lo: 4'd5, hi: 4'd9, err: 1'b0});
        run_sweep(2, 0, '{cfg: 4'd2, lo: 4'd2, hi: 4'd3, err: 1'b0});
        run_sweep(3, 1, '{cfg: 4'd7, lo: 4'd0, hi: 4'd15, err: 1'b0});
        run_sweep(3, 2, '{cfg: 4'd0, lo: 4'd0, hi: 4'd0, err: 1'b0});

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
